// File: rtl/echo_mixer.sv
// Echo mixer: adds feedback-scaled and mix-scaled wet samples to the dry sample through one shared multiplier.
// Define ECHO_MIXER_SAT_EN to clamp out-of-range sums; otherwise sums wrap to SAMPLE_W bits.
module echo_mixer #(
    parameter int SAMPLE_W = 16,
    parameter int GAIN_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] dry_in,
    input  logic [SAMPLE_W-1:0] wet_in,
    input  logic [GAIN_W-1:0]   fb_gain,
    input  logic [GAIN_W-1:0]   mix_gain,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] wr_sample,
    output logic [SAMPLE_W-1:0] dac_sample,
    output logic                overrun
);

    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam int SUM_W  = SAMPLE_W + 1;
    localparam logic [SAMPLE_W-1:0] MID_SCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC_FB, CALC_MIX, HOLD} state_t;

    state_t                      r_state;
    logic                        r_in_ready;
    logic                        r_out_valid;
    logic                        r_overrun;
    logic signed [SAMPLE_W-1:0]  r_dry_s;
    logic signed [SAMPLE_W-1:0]  r_wet_s;
    logic [GAIN_W-1:0]           r_fb_gain;
    logic [GAIN_W-1:0]           r_mix_gain;
    logic [SAMPLE_W-1:0]         r_wr_sample;
    logic [SAMPLE_W-1:0]         r_dac_sample;

    logic [GAIN_W-1:0]           w_gain;
    logic signed [PROD_W-1:0]    w_wet_ext;
    logic signed [PROD_W-1:0]    w_gain_ext;
    logic signed [PROD_W-1:0]    w_prod;
    logic signed [PROD_W-1:0]    w_prod_sh;
    logic signed [SUM_W-1:0]     w_sum;
    logic [SAMPLE_W-1:0]         w_result;
    logic                        w_unused;

    // Map the SAMPLE_W+1 bit signed sum back to offset-binary, clamping or wrapping.
    function automatic logic [SAMPLE_W-1:0] sat_conv(input logic signed [SUM_W-1:0] s);
        logic [SAMPLE_W-1:0] res;
`ifdef ECHO_MIXER_SAT_EN
        if (s[SUM_W-1] != s[SUM_W-2])
            res = s[SUM_W-1] ? {SAMPLE_W{1'b0}} : {SAMPLE_W{1'b1}};
        else
            res = {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
`else
        res = {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
`endif
        return res;
    endfunction

    // The multiplier is shared: the state picks which captured gain feeds it.
    assign w_gain     = (r_state == CALC_FB) ? r_fb_gain : r_mix_gain;
    assign w_wet_ext  = {{(GAIN_W+1){r_wet_s[SAMPLE_W-1]}}, r_wet_s};
    assign w_gain_ext = {{(SAMPLE_W+1){1'b0}}, w_gain};
    assign w_prod     = w_wet_ext * w_gain_ext;
    assign w_prod_sh  = w_prod >>> GAIN_W;
    assign w_sum      = {r_dry_s[SAMPLE_W-1], r_dry_s} + w_prod_sh[SUM_W-1:0];
    assign w_result   = sat_conv(w_sum);
    assign w_unused   = ^{w_prod_sh[PROD_W-1:SUM_W], w_sum[SUM_W-1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_overrun    <= 1'b0;
            r_dry_s      <= '0;
            r_wet_s      <= '0;
            r_fb_gain    <= '0;
            r_mix_gain   <= '0;
            r_wr_sample  <= MID_SCALE;
            r_dac_sample <= MID_SCALE;
        end else begin
            if (in_valid && (r_state != IDLE))
                r_overrun <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dry_s    <= {~dry_in[SAMPLE_W-1], dry_in[SAMPLE_W-2:0]};
                        r_wet_s    <= {~wet_in[SAMPLE_W-1], wet_in[SAMPLE_W-2:0]};
                        r_fb_gain  <= fb_gain;
                        r_mix_gain <= mix_gain;
                        r_in_ready <= 1'b0;
                        r_state    <= CALC_FB;
                    end
                end
                CALC_FB: begin
                    r_wr_sample <= w_result;
                    r_state     <= CALC_MIX;
                end
                CALC_MIX: begin
                    r_dac_sample <= w_result;
                    r_out_valid  <= 1'b1;
                    r_state      <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign overrun    = r_overrun;
    assign wr_sample  = r_wr_sample;
    assign dac_sample = r_dac_sample;

endmodule

// File: tb/tb_echo_mixer.sv
// Self-checking bench for echo_mixer: directed corner pairs plus randomized pairs against an arithmetic reference.
module tb_echo_mixer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dry_in;
    logic [15:0] wet_in;
    logic [7:0]  fb_gain;
    logic [7:0]  mix_gain;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] wr_sample;
    logic [15:0] dac_sample;
    logic        overrun;

    int          checks;
    int          failures;
    logic        exp_ovr;
    logic [15:0] prev_dac;

    echo_mixer #(.SAMPLE_W(16), .GAIN_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dry_in     (dry_in),
        .wet_in     (wet_in),
        .fb_gain    (fb_gain),
        .mix_gain   (mix_gain),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .wr_sample  (wr_sample),
        .dac_sample (dac_sample),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: offset-binary to integer, scale wet by g/256 rounding toward -inf, add, clamp or wrap.
    function automatic logic [15:0] model(input logic [15:0] dry, input logic [15:0] wet,
                                          input logic [7:0] g);
        int          ds;
        int          ws;
        int          sum;
        logic [31:0] off;
        ds  = int'(dry) - 32768;
        ws  = int'(wet) - 32768;
        sum = ds + ((ws * int'(g)) >>> 8);
`ifdef ECHO_MIXER_SAT_EN
        if (sum > 32767)  sum = 32767;
        if (sum < -32768) sum = -32768;
`endif
        off = 32'(sum + 32768);
        return off[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_pair(input logic [15:0] d, input logic [15:0] w, input logic [7:0] fb,
                            input logic [7:0] mix, input logic [15:0] ewr, input logic [15:0] edac,
                            input int hold, input bit ovr);
        in_valid  = 1'b1;
        dry_in    = d;
        wet_in    = w;
        fb_gain   = fb;
        mix_gain  = mix;
        out_ready = (hold == 0);
        tick;
        in_valid = 1'b0;
        dry_in   = 16'($urandom);
        wet_in   = 16'($urandom);
        fb_gain  = 8'($urandom);
        mix_gain = 8'($urandom);
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        chk("fb_out_valid", 32'(out_valid), 32'd0);
        tick;
        chk("fb_wr_sample", 32'(wr_sample), 32'(ewr));
        chk("fb_dac_unchanged", 32'(dac_sample), 32'(prev_dac));
        chk("mix_out_valid", 32'(out_valid), 32'd0);
        tick;
        chk("hold_out_valid", 32'(out_valid), 32'd1);
        chk("hold_dac_sample", 32'(dac_sample), 32'(edac));
        chk("hold_wr_sample", 32'(wr_sample), 32'(ewr));
        for (int i = 0; i < hold; i++) begin
            if (ovr && i == 1) begin
                in_valid = 1'b1;
                dry_in   = ~d;
                wet_in   = ~w;
            end
            tick;
            if (ovr && i == 1) exp_ovr = 1'b1;
            in_valid = 1'b0;
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_wr", 32'(wr_sample), 32'(ewr));
            chk("stall_dac", 32'(dac_sample), 32'(edac));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_overrun", 32'(overrun), 32'(exp_ovr));
        end
        out_ready = 1'b1;
        tick;
        chk("done_out_valid", 32'(out_valid), 32'd0);
        chk("done_in_ready", 32'(in_ready), 32'd1);
        chk("done_overrun", 32'(overrun), 32'(exp_ovr));
        prev_dac  = edac;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        logic [15:0] w;
        logic [7:0]  fb;
        logic [7:0]  mx;
        checks    = 0;
        failures  = 0;
        exp_ovr   = 1'b0;
        prev_dac  = 16'h8000;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dry_in    = '0;
        wet_in    = '0;
        fb_gain   = '0;
        mix_gain  = '0;
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_wr", 32'(wr_sample), 32'h8000);
        chk("rst_dac", 32'(dac_sample), 32'h8000);
        chk("rst_overrun", 32'(overrun), 32'd0);
        tick;
        rst = 1'b0;
        tick;

        run_pair(16'h8000, 16'hC000, 8'h80, 8'hFF, 16'hA000, 16'hBFC0, 0, 1'b0);
`ifdef ECHO_MIXER_SAT_EN
        run_pair(16'hF000, 16'hF000, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, 1, 1'b0);
        run_pair(16'h0000, 16'h0000, 8'hFF, 8'hFF, 16'h0000, 16'h0000, 0, 1'b0);
`else
        run_pair(16'hF000, 16'hF000, 8'hFF, 8'hFF, 16'h5F90, 16'h5F90, 1, 1'b0);
        run_pair(16'h0000, 16'h0000, 8'hFF, 8'hFF, 16'h8080, 16'h8080, 0, 1'b0);
`endif
        run_pair(16'h1234, 16'h7777, 8'h00, 8'h00, 16'h1234, 16'h1234, 0, 1'b0);

        // Long stall with an offered pair during HOLD, then a fresh pair.
        run_pair(16'h4321, 16'h9ABC, 8'h40, 8'hC0, model(16'h4321, 16'h9ABC, 8'h40),
                 model(16'h4321, 16'h9ABC, 8'hC0), 10, 1'b1);
        run_pair(16'h2468, 16'hE000, 8'h33, 8'h99, model(16'h2468, 16'hE000, 8'h33),
                 model(16'h2468, 16'hE000, 8'h99), 2, 1'b0);

        // Asynchronous reset while the pair sits in CALC_MIX.
        in_valid = 1'b1;
        dry_in   = 16'h7000;
        wet_in   = 16'h3000;
        fb_gain  = 8'h55;
        mix_gain = 8'hAA;
        tick;
        in_valid = 1'b0;
        tick;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_wr", 32'(wr_sample), 32'h8000);
        chk("arst_dac", 32'(dac_sample), 32'h8000);
        chk("arst_overrun", 32'(overrun), 32'd0);
        rst      = 1'b0;
        exp_ovr  = 1'b0;
        prev_dac = 16'h8000;
        tick;
        run_pair(16'h7000, 16'h3000, 8'h55, 8'hAA, model(16'h7000, 16'h3000, 8'h55),
                 model(16'h7000, 16'h3000, 8'hAA), 0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            d  = 16'($urandom);
            w  = 16'($urandom);
            fb = 8'($urandom);
            mx = 8'($urandom);
            run_pair(d, w, fb, mx, model(d, w, fb), model(d, w, mx),
                     int'($urandom_range(0, 3)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
